// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: TX FIFO plus shifter, status and read mux on the CPU bus.
// Define BUS_UART_RX_EN to build the receiver; without it rx is ignored.
module bus_uart #(
    parameter logic [15:0] BASE       = 16'hFFF0,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] data_out,
    input  logic        wren_n,
    input  logic        oen_n,
    output logic [15:0] data_in,
    output logic        sel,
    output logic        tx,
    input  logic        rx
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_TOP = 16'(CLK_DIV - 1);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic [1:0]  off;
    logic        wren_q;
    logic        wr_stb;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        status_wr;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic [1:0]  tx_state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_shift;
    logic        tx_ovf;
    logic        tx_idle;
    logic        rx_valid;
    logic        rx_ovr;
    logic        rx_ferr;
    logic [7:0]  rx_byte;
    logic [15:0] status;
    logic        unused_data;

    // BASE is 4-aligned, so the low address bits are the register offset.
    assign off = address[1:0];
    assign sel = (address[15:2] == BASE[15:2]) && (address[1:0] != 2'd3);

    // One strobe per low period of wren_n, however long the CPU holds it.
    assign wr_stb      = sel && !wren_n && wren_q;
    assign push_req    = wr_stb && (off == 2'd0);
    assign status_wr   = wr_stb && (off == 2'd1);
    assign unused_data = ^data_out[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wren_q <= 1'b1;
        else     wren_q <= wren_n;
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty &&
                        ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (baud_cnt == 16'd0)));
    assign push       = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= data_out[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (status_wr && data_out[2]) tx_ovf <= 1'b0;
            if (push_req && fifo_full && !pop) tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (pop) begin
                        tx_state <= TX_START;
                        baud_cnt <= BAUD_TOP;
                        tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
                        tx       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (baud_cnt == 16'd0) begin
                        tx_state <= TX_DATA;
                        baud_cnt <= BAUD_TOP;
                        bit_cnt  <= 3'd0;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= BAUD_TOP;
                        if (bit_cnt == 3'd7) begin
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    if (baud_cnt == 16'd0) begin
                        // Back-to-back frames: next start bit follows the stop bit directly.
                        if (pop) begin
                            tx_state <= TX_START;
                            baud_cnt <= BAUD_TOP;
                            tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
                            tx       <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    assign tx_idle = fifo_empty && (tx_state == TX_IDLE);

`ifdef BUS_UART_RX_EN
    localparam logic [15:0] HALF_TOP = 16'(CLK_DIV / 2 - 1);
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic        rx_s1, rx_s2, rx_s3;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        oen_q;
    logic        rd_rx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_ferr  <= 1'b0;
            oen_q    <= 1'b1;
            rd_rx_q  <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            oen_q <= oen_n;
            if (!oen_n) rd_rx_q <= sel && (off == 2'd2);
            // A completed RXDATA read consumes the byte.
            if (oen_n && !oen_q && rd_rx_q) rx_valid <= 1'b0;
            if (status_wr && data_out[4]) rx_ovr  <= 1'b0;
            if (status_wr && data_out[5]) rx_ferr <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF_TOP;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_cnt   <= BAUD_TOP;
                        rx_bit   <= 3'd0;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= BAUD_TOP;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (rx_valid) rx_ovr <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end
`else
    logic unused_rx;
    assign unused_rx = rx;
    assign rx_valid  = 1'b0;
    assign rx_ovr    = 1'b0;
    assign rx_ferr   = 1'b0;
    assign rx_byte   = 8'h00;
`endif

    assign status = {10'b0, rx_ferr, rx_ovr, rx_valid, tx_ovf, tx_idle, fifo_full};

    always_comb begin
        data_in = 16'h0000;
        if (sel && !oen_n) begin
            case (off)
                2'd1:    data_in = status;
                2'd2:    data_in = {8'h00, rx_byte};
                default: data_in = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart.sv
// Directed bench for bus_uart: reset state, register window, TX framing, FIFO overflow,
// mid-frame reset and, when BUS_UART_RX_EN is defined, the receiver.
module tb_bus_uart;

    localparam int unsigned CD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [15:0] data_out = 16'h0000;
    logic        wren_n = 1'b1;
    logic        oen_n = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] data_in;
    logic        sel;
    logic        tx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int s_cyc = 0;
    logic [7:0] frame_bytes [5];
    logic       a5_bits [10];

    always #5 clk = ~clk;

    bus_uart #(
        .BASE      (16'hFFF0),
        .CLK_DIV   (CD),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .data_out(data_out),
        .wren_n  (wren_n),
        .oen_n   (oen_n),
        .data_in (data_in),
        .sel     (sel),
        .tx      (tx),
        .rx      (rx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        address = addr;
        oen_n   = 1'b0;
        #1;
        check(tag, data_in, exp);
        oen_n = 1'b1;
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        address  = addr;
        data_out = data;
        wren_n   = 1'b0;
        tick();
        wren_n = 1'b1;
        tick();
    endtask

    // Expected tx for the n-th cycle after the first start bit of the 5-frame burst.
    function automatic logic stream_bit(input int n);
        int idx, f, b;
        if (n < 0) return 1'b1;
        idx = n / CD;
        f   = idx / 10;
        b   = idx % 10;
        if (f >= 5) return 1'b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return frame_bytes[f][b-1];
    endfunction

`ifdef BUS_UART_RX_EN
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CD) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CD) tick();
        end
        rx = stop;
        repeat (CD) tick();
        rx = 1'b1;
        repeat (CD) tick();
    endtask
`endif

    initial begin
        frame_bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A};
        a5_bits     = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state and the register window.
        tick();
        check("tx_in_reset", {15'b0, tx}, 16'h0001);
        tick();
        rst = 1'b0;
        tick();
        read_chk("status_reset", 16'hFFF1, 16'h0002);
        address = 16'hFFF1;
        #1;
        check("sel_status", {15'b0, sel}, 16'h0001);
        check("read_oen_high", data_in, 16'h0000);
        check("tx_reset", {15'b0, tx}, 16'h0001);
        read_chk("txdata_reads_0", 16'hFFF0, 16'h0000);
        read_chk("rxdata_reset", 16'hFFF2, 16'h0000);
        address = 16'hFFF3;
        #1;
        check("sel_above", {15'b0, sel}, 16'h0000);
        read_chk("read_above", 16'hFFF3, 16'h0000);
        address = 16'hFFEF;
        #1;
        check("sel_below", {15'b0, sel}, 16'h0000);

        // One byte, wren_n held low for 3 edges.
        address  = 16'hFFF0;
        data_out = 16'h00A5;
        wren_n   = 1'b0;
        tick();
        check("tx_before_pop", {15'b0, tx}, 16'h0001);
        tick();
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CD; j++) begin
                if (k == 0 && j == 1) wren_n = 1'b1;
                check("a5_frame", {15'b0, tx}, {15'b0, a5_bits[k]});
                if (k == 9 && j == CD - 1) read_chk("busy_end_of_stop", 16'hFFF1, 16'h0000);
                tick();
            end
        end
        read_chk("idle_after_frame", 16'hFFF1, 16'h0002);
        for (int i = 0; i < 3 * CD; i++) begin
            check("single_byte_only", {15'b0, tx}, 16'h0001);
            tick();
        end

        // Writes outside the window are ignored.
        bus_write(16'hFFF3, 16'h0055);
        bus_write(16'hFFEF, 16'h0055);
        read_chk("status_after_oow", 16'hFFF1, 16'h0002);
        for (int i = 0; i < 2 * CD; i++) begin
            check("oow_no_tx", {15'b0, tx}, 16'h0001);
            tick();
        end

        // Six back-to-back writes: one to the shifter, four to the FIFO, one dropped.
        bus_write(16'hFFF0, 16'h0001);
        s_cyc = cyc;
        bus_write(16'hFFF0, 16'h0080);
        bus_write(16'hFFF0, 16'h00FF);
        bus_write(16'hFFF0, 16'h0000);
        bus_write(16'hFFF0, 16'h005A);
        read_chk("full_no_ovf", 16'hFFF1, 16'h0001);
        bus_write(16'hFFF0, 16'h00C3);
        read_chk("overflow_set", 16'hFFF1, 16'h0005);
        bus_write(16'hFFF1, 16'h0000);
        read_chk("write0_keeps_ovf", 16'hFFF1, 16'h0005);
        bus_write(16'hFFF1, 16'h0004);
        read_chk("overflow_cleared", 16'hFFF1, 16'h0001);
        while (cyc - s_cyc < 52 * CD) begin
            check("burst_stream", {15'b0, tx}, {15'b0, stream_bit(cyc - s_cyc)});
            if (cyc - s_cyc == 50 * CD - 1) read_chk("burst_busy_last", 16'hFFF1, 16'h0000);
            if (cyc - s_cyc == 50 * CD) read_chk("burst_idle", 16'hFFF1, 16'h0002);
            tick();
        end

        // Reset seven cycles into a start bit, with a second byte queued.
        bus_write(16'hFFF0, 16'h0033);
        bus_write(16'hFFF0, 16'h0044);
        repeat (4) tick();
        check("start_bit_low", {15'b0, tx}, 16'h0000);
        rst = 1'b1;
        #1;
        check("tx_async_reset", {15'b0, tx}, 16'h0001);
        tick();
        rst = 1'b0;
        read_chk("status_after_rst", 16'hFFF1, 16'h0002);
        for (int i = 0; i < 12 * CD; i++) begin
            check("no_frame_after_rst", {15'b0, tx}, 16'h0001);
            tick();
        end

`ifdef BUS_UART_RX_EN
        send_rx(8'h3C, 1'b1);
        read_chk("rx_valid", 16'hFFF1, 16'h000A);
        read_chk("rx_data_3c", 16'hFFF2, 16'h003C);
        send_rx(8'h5A, 1'b1);
        read_chk("rx_overrun", 16'hFFF1, 16'h001A);
        read_chk("rx_data_5a", 16'hFFF2, 16'h005A);
        address = 16'hFFF2;
        oen_n   = 1'b0;
        tick();
        tick();
        oen_n = 1'b1;
        tick();
        read_chk("rx_valid_cleared", 16'hFFF1, 16'h0012);
        bus_write(16'hFFF1, 16'h0010);
        read_chk("rx_overrun_cleared", 16'hFFF1, 16'h0002);
        send_rx(8'hA5, 1'b0);
        read_chk("rx_frame_err", 16'hFFF1, 16'h0022);
        read_chk("rx_byte_kept", 16'hFFF2, 16'h005A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
